// File: rtl/kros_pkg.sv
// kros_pkg: shared widths and recorder state encoding for the KROS sequencer blocks.
package kros_pkg;
   localparam int SEQ_W = 6;
   localparam int STEP_W = 4;
   localparam int DATA_W = 10;
   localparam int ADDR_W = SEQ_W + STEP_W;
   typedef enum logic [1:0] {IDLE, WRITE, ADV, CLEAR} state_t;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: synchronises an active-low pushbutton and emits one pulse per debounced press.
module pb_debounce #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb,
   output logic pulse
);
   localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
   logic [1:0] sync;
   logic level;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         level <= 1'b1;
         cnt <= '0;
         pulse <= 1'b0;
      end else begin
         sync <= {sync[0], pb};
         pulse <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CW'(CYCLES - 1)) begin
            level <= sync[1];
            cnt <= '0;
            pulse <= level;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/seq_recorder.sv
// seq_recorder: debounced store/clear buttons drive writes of SW patterns into
// port A of the sequence RAM at {seq_num, step}.
module seq_recorder
   import kros_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int STEP_W = kros_pkg::STEP_W,
   parameter int DATA_W = kros_pkg::DATA_W
) (
   input  logic                       CLK_50,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          SW,
   input  logic                       pb_store,
   input  logic                       pb_clear,
   input  logic [SEQ_W-1:0]           seq_num,
   output logic [SEQ_W+STEP_W-1:0]    address_a,
   output logic [DATA_W-1:0]          data_a,
   output logic                       wren_a,
   output logic [STEP_W-1:0]          step_num,
   output logic                       busy
);
   state_t state, state_n;
   logic [SEQ_W-1:0] seq_lat, seq_lat_n;
   logic [DATA_W-1:0] sw_lat, sw_lat_n;
   logic [STEP_W-1:0] clr_idx, clr_idx_n, step_n;
   logic store_p, clear_p;

   pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_store (.clk(CLK_50), .rst_n(reset), .pb(pb_store), .pulse(store_p));
   pb_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear (.clk(CLK_50), .rst_n(reset), .pb(pb_clear), .pulse(clear_p));

   always_comb begin
      state_n = state;
      seq_lat_n = seq_lat;
      sw_lat_n = sw_lat;
      clr_idx_n = clr_idx;
      step_n = step_num;
      case (state)
         IDLE: begin
            // Tracking seq_num while idle restarts editing at step 0 on any change.
            step_n = (seq_num != seq_lat) ? '0 : step_num;
            seq_lat_n = seq_num;
            if (clear_p) begin
               state_n = CLEAR;
               clr_idx_n = '0;
            end else if (store_p) begin
               state_n = WRITE;
               sw_lat_n = SW;
            end
         end
         WRITE: state_n = ADV;
         ADV: begin
            step_n = step_num + 1'b1;
            state_n = IDLE;
         end
         CLEAR: begin
            clr_idx_n = clr_idx + 1'b1;
            if (&clr_idx) begin
               step_n = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         seq_lat <= '0;
         sw_lat <= '0;
         clr_idx <= '0;
         step_num <= '0;
         wren_a <= 1'b0;
         address_a <= '0;
         data_a <= '0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         seq_lat <= seq_lat_n;
         sw_lat <= sw_lat_n;
         clr_idx <= clr_idx_n;
         step_num <= step_n;
         wren_a <= (state_n == WRITE) || (state_n == CLEAR);
         busy <= state_n != IDLE;
         if (state_n == WRITE) begin
            address_a <= {seq_lat_n, step_n};
            data_a <= sw_lat_n;
         end else if (state_n == CLEAR) begin
            address_a <= {seq_lat_n, clr_idx_n};
            data_a <= '0;
         end
      end
   end
endmodule

// File: tb/tb_seq_recorder.sv
// tb_seq_recorder: randomized scoreboard bench for seq_recorder with a queue-based reference model.
module tb_seq_recorder;
   logic CLK_50 = 1'b0;
   logic reset = 1'b0;
   logic [9:0] SW = '0;
   logic pb_store = 1'b1;
   logic pb_clear = 1'b1;
   logic [5:0] seq_num = '0;
   logic [9:0] address_a, data_a;
   logic wren_a, busy;
   logic [3:0] step_num;

   seq_recorder #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK_50(CLK_50), .reset(reset), .SW(SW), .pb_store(pb_store), .pb_clear(pb_clear),
      .seq_num(seq_num), .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
      .step_num(step_num), .busy(busy)
   );

   always #10 CLK_50 = ~CLK_50;

   typedef struct {logic [9:0] a; logic [9:0] d;} wr_t;
   wr_t expq[$];
   logic [9:0] ram [1024];
   logic [9:0] exp_ram [1024];
   int checks = 0, failures = 0;
   int wr_cnt = 0, busy_cnt = 0;
   int m_step = 0, m_seq = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   always @(negedge CLK_50) begin : monitor
      wr_t e;
      if (busy) busy_cnt++;
      if (wren_a) begin
         wr_cnt++;
         ram[address_a] = data_a;
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write got=%0h:%0h exp=none", address_a, data_a);
         end else begin
            e = expq.pop_front();
            check("wr_addr", 32'(address_a), 32'(e.a));
            check("wr_data", 32'(data_a), 32'(e.d));
         end
      end
   end

   task automatic push(input int step, input logic [9:0] d);
      wr_t w;
      w.a = {6'(m_seq), 4'(step)};
      w.d = d;
      expq.push_back(w);
      exp_ram[w.a] = d;
   endtask

   task automatic m_store(input logic [9:0] d);
      SW = d;
      push(m_step, d);
      m_step = (m_step + 1) % 16;
   endtask

   task automatic m_clear(input int n);
      for (int i = 0; i < n; i++) push(i, 10'h000);
      m_step = 0;
   endtask

   task automatic set_seq(input int s);
      if (s != m_seq) m_step = 0;
      m_seq = s;
      seq_num = 6'(s);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK_50);
      #1;
   endtask

   task automatic press(input bit clr);
      if (clr) pb_clear = 1'b0;
      else pb_store = 1'b0;
      cyc(10);
      if (clr) pb_clear = 1'b1;
      else pb_store = 1'b1;
      cyc(10);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge CLK_50);
      while (busy && n < 60) begin
         @(negedge CLK_50);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
      check("step_num", 32'(step_num), 32'(m_step));
      check("queue_drained", 32'(expq.size()), 32'd0);
      cyc(1);
   endtask

   initial begin
      int b0, w0, base, n;
      #5;
      check("rst_wren", 32'(wren_a), 32'd0);
      check("rst_addr", 32'(address_a), 32'd0);
      check("rst_data", 32'(data_a), 32'd0);
      check("rst_step", 32'(step_num), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      cyc(3);
      reset = 1'b1;
      cyc(3);

      set_seq(3);
      b0 = busy_cnt;
      m_store(10'h2A5);
      press(0);
      wait_idle();
      check("store_busy_cycles", 32'(busy_cnt - b0), 32'd2);
      check("store_addr_hold", 32'(address_a), 32'h030);

      set_seq(0);
      for (int i = 0; i < 17; i++) begin
         m_store(10'(i));
         press(0);
         wait_idle();
      end

      w0 = wr_cnt;
      m_store(10'(($urandom() & 10'h3FF) | 10'h1));
      for (int i = 0; i < 10; i++) begin
         pb_store = (i % 2 == 0) ? 1'b0 : 1'b1;
         cyc(2);
      end
      check("bounce_no_early", 32'(wr_cnt), 32'(w0));
      press(0);
      wait_idle();
      check("bounce_one_write", 32'(wr_cnt - w0), 32'd1);

      set_seq(5);
      for (int i = 0; i < 7; i++) begin
         m_store(10'($urandom_range(1, 1023)));
         press(0);
         wait_idle();
      end
      b0 = busy_cnt;
      m_clear(16);
      fork
         press(1);
         begin
            cyc(3);
            press(0);
         end
      join
      wait_idle();
      check("clear_busy_cycles", 32'(busy_cnt - b0), 32'd16);

      for (int i = 0; i < 2; i++) begin
         m_store(10'($urandom_range(1, 1023)));
         press(0);
         wait_idle();
      end
      m_clear(16);
      fork
         press(0);
         press(1);
         begin
            cyc(12);
            seq_num = 6'd6;
         end
      join
      m_seq = 6;
      m_step = 0;
      wait_idle();

      for (int i = 0; i < 12; i++) begin
         set_seq(int'($urandom_range(0, 7)));
         cyc(2);
         if ($urandom_range(0, 4) == 0) begin
            m_clear(16);
            press(1);
         end else begin
            m_store(10'($urandom()));
            press(0);
         end
         wait_idle();
      end

      set_seq(5);
      cyc(2);
      for (int i = 0; i < 16; i++) begin
         m_store(10'($urandom_range(1, 1023)));
         press(0);
         wait_idle();
      end
      base = wr_cnt;
      m_clear(8);
      fork
         press(1);
         begin
            n = 0;
            while (wr_cnt < base + 8 && n < 100) begin
               @(posedge CLK_50);
               n++;
            end
            check("reset_trigger", 32'(wr_cnt), 32'(base + 8));
            #1 reset = 1'b0;
            #1;
            check("midrst_wren", 32'(wren_a), 32'd0);
            check("midrst_addr", 32'(address_a), 32'd0);
            check("midrst_data", 32'(data_a), 32'd0);
            check("midrst_step", 32'(step_num), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
            cyc(2);
            reset = 1'b1;
         end
      join
      m_step = 0;
      wait_idle();
      for (int i = 0; i < 16; i++)
         check($sformatf("ram_%03h", 10'h050 + i), 32'(ram[10'h050 + i]), 32'(exp_ram[10'h050 + i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
